alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the 16-bit combinational ALU in the execute stage.
//  Adds valid/ready handshakes on both sides, a registered result with NZCV flags,
//  arithmetic shift and XOR, and an iterative multi-cycle multiply.
//  Sits between the operand-forwarding mux and the EX/MEM register.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=4)
// PORTS
//  clk        in   1      sole clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands/command valid
//  in_ready   out  1      block accepts operands this cycle
//  com        in   4      operation code (see BEHAVIOUR)
//  ina        in   WIDTH  operand A
//  inb        in   WIDTH  operand B / shift amount
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result this cycle
//  out        out  WIDTH  result
//  flags      out  4      {N,Z,C,V} of result
//  err        out  1      accepted com was illegal
//  busy       out  1      multiply in progress
// BEHAVIOUR
//  Reset: out_valid=0, out=0, flags=0, err=0, busy=0, state=IDLE, mul counter=0; in-flight MUL aborted.
//  Op codes: 0 THA=ina, 1 THB=inb, 2 AND, 3 OR, 4 SL=ina<<inb, 5 SR logical, 6 ADD, 7 SUB=ina-inb,
//   8 SRA arithmetic, 9 XOR, 10 MUL=low WIDTH bits of ina*inb (unsigned), 11-15 illegal.
//  Shifts use the full inb value: inb>=WIDTH gives 0 for SL/SR, all-sign-bits for SRA.
//  Illegal op: out=0, flags={0,1,0,0}, err=1; otherwise err=0. Arithmetic wraps mod 2^WIDTH.
//  Flags: N=out[WIDTH-1]; Z=(out==0); C=carry-out for ADD, borrow (ina<inb unsigned) for SUB, else 0;
//   V=signed overflow for ADD/SUB, else 0.
//  Handshake: transfer when valid&ready high at the same rising edge. out/flags/err hold stable
//   while out_valid=1 and out_ready=0. out_valid drops the cycle after transfer unless a new result loads.
//  in_ready = (state==IDLE) && (!out_valid || out_ready) -- combinational.
//  FSM IDLE: accept non-MUL op -> result registered same edge; out_valid=1 next cycle
//   (latency 1, throughput 1/cycle under continuous out_ready). Accept MUL -> latch A,B; busy=1; go MUL.
//  FSM MUL: shift-add, one bit of B per cycle, WIDTH cycles. On last iteration: if output slot free
//   (!out_valid || out_ready) load result, busy=0, go IDLE; else go WAIT.
//  FSM WAIT: hold product; load it on first cycle slot frees, busy=0, go IDLE.
//  MUL latency: accept at edge N -> out_valid=1 after edge N+WIDTH when unstalled. No ops accepted while busy.
//  Inputs ignored when in_ready=0; in_valid need not be held while not ready (no protocol check).
//  rst asserted in any state overrides all other activity that edge.
// TESTING (WIDTH=16)
//  ADD 0x7FFF+0x0001, out_ready=1 -> out=0x8000, flags N=1 Z=0 C=0 V=1, out_valid one cycle after accept.
//  SUB 0x0003-0x0005 -> out=0xFFFE, N=1 C=1 V=0; SUB 5-5 -> out=0, Z=1.
//  SRA 0x8000 by 4 -> 0xF800; SR 0x8000 by 4 -> 0x0800; SL 0x0001 by 16 -> 0x0000; SRA 0x8000 by 20 -> 0xFFFF.
//  MUL 0x0123*0x0011 -> 0x1353 exactly 16 cycles after accept, busy=1 meanwhile, in_ready=0 throughout;
//   repeat with out_ready=0 for 5 cycles at completion -> WAIT holds, result delivered unchanged.
//  Back-to-back 4 ops with out_ready toggling 1,0,1,1 -> no loss/duplication, results in order, stable while stalled.
//  rst mid-MUL (cycle 7) -> out_valid=0, busy=0, in_ready=1 next cycle; illegal com=12 -> out=0, Z=1, err=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides, NZCV flags
// and an iterative shift-add multiplier.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       com,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             err,
  output logic             busy
);

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ShMax   = WIDTH'(WIDTH);

  localparam logic [3:0] OpTha = 4'd0;
  localparam logic [3:0] OpThb = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpSl  = 4'd4;
  localparam logic [3:0] OpSr  = 4'd5;
  localparam logic [3:0] OpAdd = 4'd6;
  localparam logic [3:0] OpSub = 4'd7;
  localparam logic [3:0] OpSra = 4'd8;
  localparam logic [3:0] OpXor = 4'd9;
  localparam logic [3:0] OpMul = 4'd10;

  typedef enum logic [1:0] {StIdle, StMul, StWait} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   add_full, sub_full;
  logic             sh_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;

  logic             slot_free, accept, load;
  logic [WIDTH-1:0] load_res, mul_step;
  logic             load_c, load_v, load_err;

  // Single-cycle datapath for every op except MUL.
  always_comb begin
    add_full = {1'b0, ina} + {1'b0, inb};
    sub_full = {1'b0, ina} - {1'b0, inb};
    sh_big   = (inb >= ShMax);
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_err  = 1'b0;
    case (com)
      OpTha: alu_res = ina;
      OpThb: alu_res = inb;
      OpAnd: alu_res = ina & inb;
      OpOr:  alu_res = ina | inb;
      OpSl:  alu_res = sh_big ? '0 : ina << inb;
      OpSr:  alu_res = sh_big ? '0 : ina >> inb;
      OpAdd: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (ina[WIDTH-1] == inb[WIDTH-1]) && (alu_res[WIDTH-1] != ina[WIDTH-1]);
      end
      OpSub: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];  // borrow
        alu_v   = (ina[WIDTH-1] != inb[WIDTH-1]) && (alu_res[WIDTH-1] != ina[WIDTH-1]);
      end
      OpSra: alu_res = sh_big ? {WIDTH{ina[WIDTH-1]}} : WIDTH'($signed(ina) >>> inb);
      OpXor: alu_res = ina ^ inb;
      OpMul: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready  = (state_q == StIdle) && slot_free;
    accept    = in_valid && in_ready;
    mul_step  = acc_q + (mb_q[0] ? ma_q : '0);

    state_d  = state_q;
    acc_d    = acc_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    load_res = alu_res;
    load_c   = alu_c;
    load_v   = alu_v;
    load_err = alu_err;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (com == OpMul) begin
            acc_d   = '0;
            ma_d    = ina;
            mb_d    = inb;
            cnt_d   = '0;
            state_d = StMul;
          end else begin
            load = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d = mul_step;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (slot_free) begin
            load     = 1'b1;
            load_res = mul_step;
            load_c   = 1'b0;
            load_v   = 1'b0;
            load_err = 1'b0;
            state_d  = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (slot_free) begin
          load     = 1'b1;
          load_res = acc_q;
          load_c   = 1'b0;
          load_v   = 1'b0;
          load_err = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A load only happens when the slot is free, so a stalled result is never overwritten.
    out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_d       = load ? load_res : out_q;
    flags_d     = load ? {load_res[WIDTH-1], load_res == '0, load_c, load_v} : flags_q;
    err_d       = load ? load_err : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle);

endmodule
